// File: rtl/doppio_pkg.sv
// Items shared between the Doppio aggregator and the core stream serializer:
// lane geometry, lane/bit tag types and the serializer state encoding.
package doppio_pkg;

  localparam int unsigned NumCores  = 4;
  localparam int unsigned CoreWidth = 64;

  typedef logic [$clog2(NumCores)-1:0]  core_id_t;
  typedef logic [$clog2(CoreWidth)-1:0] bit_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StGap,
    StFin
  } ser_state_e;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter that paces the idle gap between serial bit transfers.
// expire is high while the count sits at 1, i.e. on the final gap cycle.
module gap_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/core_stream_serializer.sv
// Snapshots the aggregator's parallel core lanes on START and streams them out one
// tagged bit at a time over valid/ready, with a programmable idle gap between bits.
module core_stream_serializer
  import doppio_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCores,
  parameter int unsigned WIDTH     = CoreWidth,
  parameter int unsigned GAP_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [GAP_W-1:0]             tick_div,
  input  logic [WIDTH-1:0]             bin_in [NUM_CORES],
  output logic                         bit_out,
  output logic                         bit_valid,
  input  logic                         bit_ready,
  output logic [$clog2(NUM_CORES)-1:0] core_id,
  output logic [$clog2(WIDTH)-1:0]     bit_idx,
  output logic                         frame_start,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned CW = $clog2(NUM_CORES);
  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [CW-1:0] CoreLast = CW'(NUM_CORES - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(WIDTH - 1);

  ser_state_e       state_q;
  logic [WIDTH-1:0] shadow_q [NUM_CORES];
  logic [CW-1:0]    core_q;
  logic [IW-1:0]    idx_q;
  logic             bit_q, valid_q, fs_q, busy_q, done_q;

  logic          last_bit, gap_load, gap_en, gap_expire;
  logic [CW-1:0] core_nxt;
  logic [IW-1:0] idx_nxt;

  assign last_bit = (core_q == CoreLast) && (idx_q == IdxLast);
  assign gap_load = (state_q == StSend) && bit_ready && !last_bit && (tick_div != '0);
  assign gap_en   = (state_q == StGap);

  // Position of the bit after the one currently presented; unused on the last bit.
  always_comb begin
    core_nxt = core_q;
    idx_nxt  = idx_q + 1'b1;
    if (idx_q == IdxLast) begin
      core_nxt = core_q + 1'b1;
      idx_nxt  = '0;
    end
  end

  gap_timer #(
    .W(GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (tick_div),
    .en       (gap_en),
    .expire   (gap_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shadow_q <= '{default: '0};
      core_q   <= '0;
      idx_q    <= '0;
      bit_q    <= 1'b0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          shadow_q <= bin_in;
          core_q   <= '0;
          idx_q    <= '0;
          bit_q    <= bin_in[0][0];
          valid_q  <= 1'b1;
          fs_q     <= 1'b1;
          state_q  <= StSend;
        end
        StSend: begin
          // Without bit_ready nothing changes, so every output holds.
          if (bit_ready) begin
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            if (last_bit) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              core_q  <= '0;
              idx_q   <= '0;
              bit_q   <= 1'b0;
            end else begin
              core_q <= core_nxt;
              idx_q  <= idx_nxt;
              bit_q  <= shadow_q[core_nxt][idx_nxt];
              if (tick_div == '0) begin
                valid_q <= 1'b1;
                fs_q    <= (idx_nxt == '0);
              end else begin
                state_q <= StGap;
              end
            end
          end
        end
        StGap: begin
          if (gap_expire) begin
            state_q <= StSend;
            valid_q <= 1'b1;
            fs_q    <= (idx_q == '0);
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bit_out     = bit_q;
  assign bit_valid   = valid_q;
  assign core_id     = core_q;
  assign bit_idx     = idx_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/core_stream_serializer.md
Name: core_stream_serializer

Overview:
- Sits directly downstream of the Doppio aggregator.
- On START, takes a snapshot of the NUM_CORES parallel WIDTH-bit core streams.
- Sends the snapshot out one bit at a time over a valid/ready link toward the GUI transport. Order is core 0 to core NUM_CORES-1, and within each core bit index 0 to WIDTH-1.
- Tags every bit with its core ID and bit index. A programmable idle gap between bits sets the output bit rate.

Parameters:
- NUM_CORES, 4, number of core lanes presented by the aggregator.
- WIDTH, 64, bits per core lane.
- GAP_W, 8, width of the TICK_DIV input.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request a frame; sampled only in IDLE.
- TICK_DIV  in  GAP_W  idle cycles inserted after each transfer; 0 means back-to-back.
- BIN_IN  in  [0:WIDTH-1] x [0:NUM_CORES-1]  unpacked core lanes from the aggregator.
- BIT_OUT  out  1  current serial bit.
- BIT_VALID  out  1  BIT_OUT and its tags are valid.
- BIT_READY  in  1  consumer accepts the current bit.
- CORE_ID  out  $clog2(NUM_CORES)  lane of the current bit.
- BIT_IDX  out  $clog2(WIDTH)  index of the current bit within its lane.
- FRAME_START  out  1  high with BIT_VALID when BIT_IDX==0.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse after the last bit of the frame.

Behaviour:
- Reset: while RST_N=0, all outputs are 0, the FSM is in IDLE, counters are 0 and the shadow registers are cleared. Reset is asynchronous; deassertion is synchronous to CLK.
- FSM states: IDLE, LOAD, SEND, GAP, FIN.
- IDLE: START=1 moves to LOAD.
- LOAD (exactly 1 cycle):
  - Copy all BIN_IN lanes into shadow registers; core=0, idx=0.
  - Go to SEND.
  - Changes on BIN_IN after LOAD do not affect the frame.
- SEND:
  - BIT_VALID=1; BIT_OUT=shadow[core][idx]; CORE_ID=core; BIT_IDX=idx.
  - Transfer occurs only on a cycle with BIT_VALID and BIT_READY both high.
  - While BIT_READY=0, every output holds stable.
- After a transfer:
  - idx==WIDTH-1 and core==NUM_CORES-1: go to FIN.
  - idx==WIDTH-1 otherwise: core+1, idx=0.
  - Otherwise: idx+1.
  - Then, unless going to FIN: TICK_DIV==0 goes straight to SEND (back-to-back); else go to GAP.
- GAP:
  - BIT_VALID=0; the gap counter loads TICK_DIV and counts down.
  - Exits to SEND on the cycle the count reaches 1, giving exactly TICK_DIV cycles with valid low.
  - TICK_DIV is sampled at each transfer.
- FIN: DONE=1 for one cycle, BUSY=1, then IDLE. BUSY drops the cycle after DONE.
- Latency: START high at edge N gives LOAD at N+1 and the first BIT_VALID at N+2.
- START is ignored in every state except IDLE. START held high re-triggers a new frame immediately after FIN.
- There is no early abort; only RST_N terminates a frame. After reset, the next START restarts at core 0, bit 0.
- Counters never wrap past WIDTH-1 or NUM_CORES-1; the FSM leaves SEND first.
- Frame size is NUM_CORES*WIDTH transfers (256 at defaults).

Decomposition:
- doppio_pkg holds the shared items:
  - NUM_CORES and CORE_WIDTH constants, shared with the aggregator.
  - core_id_t and bit_idx_t typedefs.
  - The serializer state enum (IDLE, LOAD, SEND, GAP, FIN).
- One sub-module: gap_timer, a loadable down-counter (load, count, expire) used for the GAP state.
- The FSM, shadow registers and bit/core counters live in core_stream_serializer.

Test Plan:
- Reset: RST_N=0 with random inputs -> BIT_VALID, BUSY, DONE, BIT_OUT, CORE_ID and BIT_IDX all 0; START ignored while in reset.
- Full frame:
  - Stimulus: TICK_DIV=0, READY=1; lanes 0xAAAA_AAAA_AAAA_AAAA, all-ones, all-zeros, 0x0123_4567_89AB_CDEF; START pulse at edge 0.
  - Response: 256 transfers on cycles 2..257 with bit order matching index 0 first; FRAME_START on cycles 2, 66, 130 and 194; DONE on cycle 258.
- Backpressure: READY=0 for 5 cycles while BIT_IDX=10, core 1 -> BIT_OUT, CORE_ID=1 and BIT_IDX=10 held stable; no bit skipped or duplicated.
- Snapshot and START-while-busy:
  - Stimulus: rewrite BIN_IN to all zeros 1 cycle after LOAD, and pulse START mid-frame.
  - Response: the output stream equals the original snapshot, and only one DONE is produced.
- Gap: TICK_DIV=3, READY=1 -> exactly 3 cycles with BIT_VALID=0 between successive transfers; the frame takes 256 transfers + 255*3 gap cycles.
- Reset mid-frame:
  - Stimulus: RST_N low at transfer 100, then released, then START.
  - Response: outputs clear immediately (asynchronously); the new frame begins at CORE_ID=0, BIT_IDX=0 and completes normally.
